cache_refill_ctrl: RTL
======================

# cache_refill_ctrl

Miss-handling controller on the fill side of the direct-mapped L1 data cache. It watches the CPU read address and the cache hit flag. On a read miss it fetches the aligned 4-word block from main memory over a req/ack handshake, then drives the cache's block-fill port with a one-cycle cWrite strobe. It sits between the cache, the CPU stall input and the main-memory read port.

## Interface
Parameters:
- WORD, 32, data word width
- ADDRESSL, 12, cache index width
- TAG, 3, tag width; full address width is ADDRESSL+TAG = 15

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- address  input  15  CPU word address
- cRead  input  1  CPU read request
- hit  input  1  cache hit flag, combinational from the cache for `address`
- ready  output  1  CPU may proceed; low means stall
- memReq  output  1  main-memory read request
- memAdr  output  15  main-memory word address
- memAck  input  1  memData valid this cycle; consumes the current request
- memData  input  32  main-memory read data
- cWrite  output  1  cache fill strobe, one cycle
- adr0..adr3  output  15 each  fill addresses, base+0..base+3
- block0..block3  output  32 each  fill data words
- misses  output  15  count of misses serviced

## Operation
- Block base = {address[14:2], 2'b00}, latched on miss detection.
- FSM states: IDLE, REQ, FILL.
- IDLE:
  - ready = !cRead || hit (combinational).
  - If cRead && !hit: latch base, cnt←0, misses←misses+1, go to REQ.
- REQ:
  - memReq=1, memAdr=base+cnt.
  - On memAck: buf[cnt]←memData.
  - If cnt==3, go to FILL; else cnt←cnt+1 and stay in REQ. memReq stays high across words.
  - ready=0.
- FILL: cWrite=1 for exactly one cycle, then return to IDLE. ready=0.
- Fill outputs:
  - adrK = base+K, blockK = buf[K].
  - Both are registered and held stable outside FILL.
- Input handling:
  - memAck outside REQ is ignored.
  - memData is sampled only on a cycle where memReq && memAck.
- Miss service is never aborted:
  - If cRead drops or address changes during REQ or FILL, the fetch completes with the latched base.
  - IDLE then re-evaluates the new address and hit.
- cnt is 2 bits and never wraps mid-block. misses wraps 0x7FFF→0.
- Reset (any state, asynchronous, active-low): state=IDLE, cnt=0, memReq=0, memAdr=0, cWrite=0, adr0..3=0, block0..3=0, buffers=0, misses=0. ready then follows the IDLE equation.

## Timing
- Cycle 0: miss seen in IDLE with ready=0. The transition happens on the clock edge.
- REQ with zero-wait memory (memAck high in the same cycle as memReq): words are captured on cycles 1–4.
- Cycle 5: FILL, cWrite=1. The cache writes on this edge.
- Cycle 6: IDLE. hit=1 for the unchanged address, so ready=1.
- Miss penalty = 6 + total memory wait cycles.
- memAdr changes only on the edge after an accepted word. Memory must not ack twice for one address.
- A new miss can be detected in the first IDLE cycle after FILL. There are no back-to-back REQ phases without an IDLE cycle.

## Structure
- Shared package cache_pkg holds:
  - WORD, ADDRESSL, TAG, ADDR_W=ADDRESSL+TAG, BLOCK_WORDS=4
  - the refill state enum {IDLE, REQ, FILL}
  - a helper for block base alignment
- The same package is used by the cache and by this block.
- Optional sub-module: refill_buffer, a 4×WORD capture register with write index and enable.
- The FSM, counter and address generation stay in cache_refill_ctrl.

## Test plan
- Reset mid-fetch: assert rst low while in REQ at cnt=2. Required: memReq=0, cWrite=0 and misses=0 immediately; after release, state is IDLE with ready=1 when cRead=0.
- Zero-wait miss: cRead=1, address=0x1235, hit=0, memAck tied high, memData=0xA0+memAdr[1:0]. Required:
  - memAdr sequence 0x1234, 0x1235, 0x1236, 0x1237
  - cWrite high only in cycle 5, with adr0..3=0x1234..0x1237 and block0..3=0xA0..0xA3
  - ready=1 in cycle 6 (cache model returns hit); misses=1
- Wait-stated memory: memAck delayed 3 cycles per word. Required: memAdr holds each address until acked, cWrite in cycle 17, block order preserved.
- Hit path: cRead=1, hit=1. Required: ready=1, memReq never asserted, misses unchanged.
- Address change during fetch: address switches 0x0010→0x7FF3 at cycle 2. Required: fill uses base 0x0010; the next IDLE detects a miss for base 0x7FF0; misses=2.
- Counter wrap: preload 0x7FFF misses via repeated misses (or force). Required: the next miss gives misses=0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the L1 data cache and its refill controller.
package cache_pkg;

    localparam int WORD        = 32;
    localparam int ADDRESSL    = 12;
    localparam int TAG         = 3;
    localparam int ADDR_W      = ADDRESSL + TAG;
    localparam int BLOCK_WORDS = 4;

    // Refill controller states
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } refillState_e;

    // Aligns a word address down to the first word of its 4-word block
    function automatic logic [ADDR_W-1:0] blockBase(input logic [ADDR_W-1:0] adr);
        return {adr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/refill_buffer.sv
// Four-word capture register for a block being fetched from main memory.
module refill_buffer #(
    parameter int WORD = cache_pkg::WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wrEn,
    input  logic [1:0]      wrIdx,
    input  logic [WORD-1:0] wrData,
    output logic [WORD-1:0] fillWord0,
    output logic [WORD-1:0] fillWord1,
    output logic [WORD-1:0] fillWord2,
    output logic [WORD-1:0] fillWord3
);
    import cache_pkg::*;

    logic [WORD-1:0] words [BLOCK_WORDS];

    // Capture the accepted memory word into its slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this buffer is a handful of flops rather than a RAM, so it is cleared on reset like any other state.
            for (int i = 0; i < BLOCK_WORDS; i++) words[i] <= '0;
        end else if (wrEn) begin
            words[wrIdx] <= wrData;
        end
    end

    // Present the stored words with the in-flight write bypassed, so the final word is usable on its capture edge
    always_comb begin
        fillWord0 = words[0];
        fillWord1 = words[1];
        fillWord2 = words[2];
        fillWord3 = words[3];
        if (wrEn) begin
            case (wrIdx)
                2'd0: fillWord0 = wrData;
                2'd1: fillWord1 = wrData;
                2'd2: fillWord2 = wrData;
                default: fillWord3 = wrData;
            endcase
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Read-miss refill controller: fetches the aligned 4-word block from main
// memory, then strobes it into the direct-mapped L1 data cache.
module cache_refill_ctrl #(
    parameter int WORD     = cache_pkg::WORD,
    parameter int ADDRESSL = cache_pkg::ADDRESSL,
    parameter int TAG      = cache_pkg::TAG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESSL+TAG-1:0]  address,
    input  logic                     cRead,
    input  logic                     hit,
    output logic                     ready,
    output logic                     memReq,
    output logic [ADDRESSL+TAG-1:0]  memAdr,
    input  logic                     memAck,
    input  logic [WORD-1:0]          memData,
    output logic                     cWrite,
    output logic [ADDRESSL+TAG-1:0]  adr0,
    output logic [ADDRESSL+TAG-1:0]  adr1,
    output logic [ADDRESSL+TAG-1:0]  adr2,
    output logic [ADDRESSL+TAG-1:0]  adr3,
    output logic [WORD-1:0]          block0,
    output logic [WORD-1:0]          block1,
    output logic [WORD-1:0]          block2,
    output logic [WORD-1:0]          block3,
    output logic [ADDRESSL+TAG-1:0]  misses
);
    import cache_pkg::*;

    localparam int ADDRW = ADDRESSL + TAG;

    refillState_e     state;
    refillState_e     nextState;
    logic [1:0]       cnt;
    logic [ADDRW-1:0] base;
    logic [ADDRW-1:0] missCount;
    logic             missDetect;
    logic             wordAccept;
    logic             lastWord;
    logic [WORD-1:0]  fillWord0;
    logic [WORD-1:0]  fillWord1;
    logic [WORD-1:0]  fillWord2;
    logic [WORD-1:0]  fillWord3;

    // memAck only counts while a request is outstanding; the fourth word ends the fetch
    assign missDetect = (state == IDLE) && cRead && !hit;
    assign wordAccept = (state == REQ) && memAck;
    assign lastWord   = wordAccept && (cnt == 2'd3);
    assign memAdr     = base + ADDRW'(cnt);
    assign misses     = missCount;

    refill_buffer #(.WORD(WORD)) buffer (
        .clk       (clk),
        .rst       (rst),
        .wrEn      (wordAccept),
        .wrIdx     (cnt),
        .wrData    (memData),
        .fillWord0 (fillWord0),
        .fillWord1 (fillWord1),
        .fillWord2 (fillWord2),
        .fillWord3 (fillWord3)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            state <= nextState;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        nextState = state;
        ready     = 1'b0;
        memReq    = 1'b0;
        cWrite    = 1'b0;
        case (state)
            IDLE: begin
                ready = !cRead || hit;
                if (missDetect) nextState = REQ;
            end
            REQ: begin
                memReq = 1'b1;
                if (lastWord) nextState = FILL;
            end
            FILL: begin
                cWrite    = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Latch the block base on a miss, step the word index per accepted word, count serviced misses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base      <= '0;
            cnt       <= '0;
            missCount <= '0;
        end else if (missDetect) begin
            base      <= blockBase(address);
            cnt       <= '0;
            missCount <= missCount + 1'b1;
        end else if (wordAccept && !lastWord) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Load the fill port on the edge into FILL; it then holds until the next refill completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr0   <= '0;
            adr1   <= '0;
            adr2   <= '0;
            adr3   <= '0;
            block0 <= '0;
            block1 <= '0;
            block2 <= '0;
            block3 <= '0;
        end else if (lastWord) begin
            adr0   <= base;
            adr1   <= base + ADDRW'(1);
            adr2   <= base + ADDRW'(2);
            adr3   <= base + ADDRW'(3);
            block0 <= fillWord0;
            block1 <= fillWord1;
            block2 <= fillWord2;
            block3 <= fillWord3;
        end
    end

endmodule
